shared_mem_arbiter: RTL and testbench

//  Arbitrates per-core load/store requests onto the single port of the shared data memory.

---
 rtl/shared_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_shared_mem_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter that funnels per-core load/store requests onto the single
// shared data-memory port, one transaction in flight (IDLE -> ISSUE -> RESP).
module shared_mem_arbiter #(
   parameter int NCORES = 2,
   parameter int TAM    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCORES-1:0]     req_valid,
   input  logic [NCORES-1:0]     req_we,
   input  logic [NCORES*TAM-1:0] req_addr,
   input  logic [NCORES*TAM-1:0] req_wdata,
   output logic [NCORES-1:0]     req_ready,
   output logic [NCORES-1:0]     resp_valid,
   output logic [NCORES*TAM-1:0] resp_data,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [TAM-1:0]        mem_addr,
   output logic [TAM-1:0]        mem_wdata,
   input  logic [TAM-1:0]        mem_rdata
);

   localparam int PW = $clog2(NCORES);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   rr_ptr, rr_nx, winner, win;
   logic            found, accept;
   logic [PW:0]     sum, inc;
   logic            sel_we, cap_we;
   logic [TAM-1:0]  sel_addr, sel_wdata, cap_addr, cap_wdata;

   // Rotating priority search starting at rr_ptr, plus the winner's payload.
   always_comb begin
      found     = 1'b0;
      winner    = '0;
      sum       = '0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int k = 0; k < NCORES; k++) begin
         sum = {1'b0, rr_ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(NCORES))
            sum = sum - (PW+1)'(NCORES);
         if (!found && req_valid[sum[PW-1:0]]) begin
            found  = 1'b1;
            winner = sum[PW-1:0];
         end
      end
      for (int i = 0; i < NCORES; i++) begin
         if (winner == PW'(i)) begin
            sel_we    = req_we[i];
            sel_addr  = req_addr[i*TAM +: TAM];
            sel_wdata = req_wdata[i*TAM +: TAM];
         end
      end
      inc = {1'b0, winner} + (PW+1)'(1);
      if (inc >= (PW+1)'(NCORES))
         inc = '0;
      rr_nx = inc[PW-1:0];
   end

   always_comb begin
      state_nx   = state;
      accept     = 1'b0;
      req_ready  = '0;
      resp_valid = '0;
      resp_data  = '0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state)
         IDLE: begin
            if (found) begin
               req_ready[winner] = 1'b1;
               accept            = 1'b1;
               state_nx          = ISSUE;
            end
         end
         ISSUE: begin
            mem_en    = 1'b1;
            mem_we    = cap_we;
            mem_addr  = cap_addr;
            mem_wdata = cap_wdata;
            state_nx  = RESP;
         end
         RESP: begin
            // Writes complete with an all-zero lane; reads forward the memory data.
            for (int i = 0; i < NCORES; i++) begin
               if (win == PW'(i)) begin
                  resp_valid[i]           = 1'b1;
                  resp_data[i*TAM +: TAM] = cap_we ? '0 : mem_rdata;
               end
            end
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         win       <= '0;
         cap_we    <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            rr_ptr    <= rr_nx;
            win       <= winner;
            cap_we    <= sel_we;
            cap_addr  <= sel_addr;
            cap_wdata <= sel_wdata;
         end
      end
   end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter (2 cores, 16-bit) with a one-cycle
// read-latency memory model on the shared port.
module tb_shared_mem_arbiter;

   localparam int NCORES = 2;
   localparam int TAM    = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NCORES-1:0]     req_valid, req_we, req_ready, resp_valid;
   logic [NCORES*TAM-1:0] req_addr, req_wdata, resp_data;
   logic                  mem_en, mem_we;
   logic [TAM-1:0]        mem_addr, mem_wdata;
   logic [TAM-1:0]        mem_rdata = '0;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   shared_mem_arbiter #(.NCORES(NCORES), .TAM(TAM)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   function automatic logic [TAM-1:0] rom(input logic [TAM-1:0] a);
      case (a)
         16'h0010: rom = 16'hBEEF;
         16'h0005: rom = 16'h5555;
         default:  rom = 16'hDEAD;
      endcase
   endfunction

   // Read data appears the cycle after the strobe.
   always @(posedge clk)
      mem_rdata <= (mem_en && !mem_we) ? rom(mem_addr) : 16'h0000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, ".mem_en"},     32'(mem_en),     32'h0);
      check({tag, ".mem_we"},     32'(mem_we),     32'h0);
      check({tag, ".mem_addr"},   32'(mem_addr),   32'h0);
      check({tag, ".mem_wdata"},  32'(mem_wdata),  32'h0);
      check({tag, ".resp_valid"}, 32'(resp_valid), 32'h0);
      check({tag, ".resp_data"},  32'(resp_data),  32'h0);
      check({tag, ".req_ready"},  32'(req_ready),  32'h0);
   endtask

   initial begin
      logic [1:0]  exp_g;
      logic [31:0] exp_d;
      rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_quiet("reset");
      check("reset.rr_ptr", 32'(dut.rr_ptr), 32'h0);

      // Single read by core1
      req_valid = 2'b10; req_we = 2'b00; req_addr = {16'h0010, 16'h0000};
      #1 check("rd.ready", 32'(req_ready), 32'h2);
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      check("rd.mem_en", 32'(mem_en), 32'h1);
      check("rd.mem_we", 32'(mem_we), 32'h0);
      check("rd.mem_addr", 32'(mem_addr), 32'h0010);
      check("rd.issue_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
      check("rd.resp_valid", 32'(resp_valid), 32'h2);
      check("rd.resp_data", 32'(resp_data), 32'hBEEF0000);
      check("rd.resp_mem_en", 32'(mem_en), 32'h0);
      check("rd.rr_ptr", 32'(dut.rr_ptr), 32'h0);
      @(negedge clk);

      // Write by core0
      req_valid = 2'b01; req_we = 2'b01; req_addr = {16'h0000, 16'h0003};
      req_wdata = {16'h0000, 16'h1234};
      #1 check("wr.ready", 32'(req_ready), 32'h1);
      @(posedge clk); #1 req_valid = '0; req_we = '0;
      @(negedge clk);
      check("wr.mem_en", 32'(mem_en), 32'h1);
      check("wr.mem_we", 32'(mem_we), 32'h1);
      check("wr.mem_addr", 32'(mem_addr), 32'h0003);
      check("wr.mem_wdata", 32'(mem_wdata), 32'h1234);
      @(negedge clk);
      check("wr.resp_valid", 32'(resp_valid), 32'h1);
      check("wr.resp_data", 32'(resp_data), 32'h0);
      check("wr.rr_ptr", 32'(dut.rr_ptr), 32'h1);
      @(negedge clk);

      // rr_ptr=1, only core0 asks; payload changes after acceptance
      req_valid = 2'b01; req_addr = {16'h0000, 16'h0005}; req_wdata = {16'h0000, 16'h7777};
      #1 check("rr.ready", 32'(req_ready), 32'h1);
      @(posedge clk); #1 req_valid = '0; req_addr = {16'h0000, 16'h00FF}; req_wdata = '0;
      @(negedge clk);
      check("hold.mem_addr", 32'(mem_addr), 32'h0005);
      check("rr.rr_ptr", 32'(dut.rr_ptr), 32'h1);
      @(negedge clk);
      check("rr.resp_valid", 32'(resp_valid), 32'h1);
      check("rr.resp_data", 32'(resp_data), 32'h00005555);

      // Contention from reset: both cores valid every cycle
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      req_valid = 2'b11; req_we = 2'b00; req_addr = {16'h0010, 16'h0005};
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         exp_g = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
         exp_d = (exp_g == 2'b01) ? 32'h00005555 : 32'hBEEF0000;
         check($sformatf("cont%0d.ready", k), 32'(req_ready), (k % 3 == 0) ? 32'(exp_g) : 32'h0);
         check($sformatf("cont%0d.mem_en", k), 32'(mem_en), (k % 3 == 1) ? 32'h1 : 32'h0);
         check($sformatf("cont%0d.resp_valid", k), 32'(resp_valid), (k % 3 == 2) ? 32'(exp_g) : 32'h0);
         check($sformatf("cont%0d.resp_data", k), 32'(resp_data), (k % 3 == 2) ? exp_d : 32'h0);
      end
      @(posedge clk); #1 req_valid = '0;

      // Reset while ISSUE is strobing a write
      @(negedge clk);
      req_valid = 2'b01; req_we = 2'b01; req_addr = {16'h0000, 16'h0007};
      req_wdata = {16'h0000, 16'hAAAA};
      #1 check("rst.ready", 32'(req_ready), 32'h1);
      @(posedge clk); #1 req_valid = '0; req_we = '0;
      @(negedge clk);
      check("rst.issue_en", 32'(mem_en), 32'h1);
      check("rst.rr_before", 32'(dut.rr_ptr), 32'h1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_quiet("rst_issue");
      check("rst_issue.rr_ptr", 32'(dut.rr_ptr), 32'h0);
      @(negedge clk);
      check("rst_issue.no_resp", 32'(resp_valid), 32'h0);
      check("rst_issue.idle_en", 32'(mem_en), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
